clock_enable_gen: RTL and testbench

CLOCK_ENABLE_GEN -- requirements
Module: clock_enable_gen

---
 rtl/clock_enable_gen.sv | 82 ++++++++
 tb/tb_clock_enable_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clock_enable_gen.sv
// Bus-phase and clock-enable generator for a 28 MHz master clock.
// Produces the 7 MHz bus strobe, bus-phase levels, E-clock phases and the CPU enable.
module clock_enable_gen #(
    parameter int SUB   = 4,
    parameter int E_DIV = 10
) (
    input  logic             clk28m,
    input  logic             reset_n,
    input  logic             turbo,
    input  logic             sync,
    output logic             clk7_en,
    output logic             c1,
    output logic             c3,
    output logic             cck,
    output logic             cck_en,
    output logic [E_DIV-1:0] eclk,
    output logic             cpu_ce,
    output logic             turbo_act
);

    localparam int SW = $clog2(SUB);
    localparam int EW = $clog2(E_DIV);

    localparam logic [SW-1:0] SUB_LAST = SW'(SUB - 1);
    localparam logic [SW-1:0] C1_END   = SW'(SUB / 2);
    localparam logic [SW-1:0] C3_BEG   = SW'(SUB / 4);
    localparam logic [SW-1:0] C3_END   = SW'(SUB / 4 + SUB / 2);
    localparam logic [EW-1:0] E_LAST   = EW'(E_DIV - 1);

    logic [SW-1:0] r_sub;
    logic [EW-1:0] r_e_cnt;
    logic          r_sync_pend;
    logic          r_turbo_act;

    logic          w_clk7_en;
    logic [EW-1:0] w_e_next;

    assign w_clk7_en = (r_sub == SUB_LAST);

    // A live sync request at the boundary counts the same as a pending one.
    always_comb begin
        w_e_next = r_e_cnt + 1'b1;
        if (r_sync_pend || sync || (r_e_cnt == E_LAST)) begin
            w_e_next = '0;
        end
    end

    always_ff @(posedge clk28m or negedge reset_n) begin
        if (!reset_n) begin
            r_sub       <= '0;
            r_e_cnt     <= '0;
            r_sync_pend <= 1'b0;
            r_turbo_act <= 1'b0;
        end else begin
            r_sub <= w_clk7_en ? '0 : r_sub + 1'b1;
            if (w_clk7_en) begin
                r_e_cnt     <= w_e_next;
                r_sync_pend <= 1'b0;
                r_turbo_act <= turbo;
            end else if (sync) begin
                r_sync_pend <= 1'b1;
            end
        end
    end

    assign clk7_en   = w_clk7_en;
    assign c1        = (r_sub < C1_END);
    assign c3        = (r_sub >= C3_BEG) && (r_sub < C3_END);
    assign cck       = ~r_e_cnt[0];
    assign cck_en    = w_clk7_en & r_e_cnt[0];
    assign turbo_act = r_turbo_act;
    // SUB is even, so odd sub values are never adjacent across the wrap.
    assign cpu_ce    = r_turbo_act ? r_sub[0] : w_clk7_en;

    always_comb begin
        eclk = '0;
        for (int i = 0; i < E_DIV; i++) begin
            eclk[i] = (r_e_cnt == EW'(i));
        end
    end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: default build plus a SUB=8 / E_DIV=6 build.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_clock_enable_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, turbo_a, sync_a;
    logic       clk7_en_a, c1_a, c3_a, cck_a, cck_en_a, cpu_ce_a, turbo_act_a;
    logic [9:0] eclk_a;

    logic       rstb_n, turbo_b, sync_b;
    logic       clk7_en_b, c1_b, c3_b, cck_b, cck_en_b, cpu_ce_b, turbo_act_b;
    logic [5:0] eclk_b;

    clock_enable_gen #(.SUB(4), .E_DIV(10)) dut_a (
        .clk28m(clk), .reset_n(reset_n), .turbo(turbo_a), .sync(sync_a),
        .clk7_en(clk7_en_a), .c1(c1_a), .c3(c3_a), .cck(cck_a), .cck_en(cck_en_a),
        .eclk(eclk_a), .cpu_ce(cpu_ce_a), .turbo_act(turbo_act_a)
    );

    clock_enable_gen #(.SUB(8), .E_DIV(6)) dut_b (
        .clk28m(clk), .reset_n(rstb_n), .turbo(turbo_b), .sync(sync_b),
        .clk7_en(clk7_en_b), .c1(c1_b), .c3(c3_b), .cck(cck_b), .cck_en(cck_en_b),
        .eclk(eclk_b), .cpu_ce(cpu_ce_b), .turbo_act(turbo_act_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int n     = 0;

    wire [16:0] obs_a = {clk7_en_a, c1_a, c3_a, cck_a, cck_en_a, cpu_ce_a, turbo_act_a, eclk_a};
    wire [12:0] obs_b = {clk7_en_b, c1_b, c3_b, cck_b, cck_en_b, cpu_ce_b, turbo_act_b, eclk_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        n++;
    endtask

    // Expected outputs of the default build, from the listed decode sets.
    function automatic logic [16:0] exp_a(input int sub, input int e, input bit ta);
        logic [9:0] one;
        logic       c7;
        one = 10'd1;
        c7  = (sub == 3);
        return {c7, (sub == 0 || sub == 1), (sub == 1 || sub == 2), (e % 2 == 0),
                (c7 && (e % 2 == 1)), (ta ? (sub % 2 == 1) : c7), ta, one << e};
    endfunction

    function automatic logic [12:0] exp_b(input int sub, input int e, input bit ta);
        logic [5:0] one;
        logic       c7;
        one = 6'd1;
        c7  = (sub == 7);
        return {c7, (sub < 4), (sub >= 2 && sub < 6), (e % 2 == 0),
                (c7 && (e % 2 == 1)), (ta ? (sub % 2 == 1) : c7), ta, one << e};
    endfunction

    bit exp_ce[15] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1};
    bit exp_ta[15] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        #300000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        reset_n = 1'b0; turbo_a = 1'b0; sync_a = 1'b0;
        rstb_n  = 1'b0; turbo_b = 1'b0; sync_b = 1'b0;
        tick(); tick();
        chk("reset_state", 32'(obs_a), 32'(exp_a(0, 0, 0)));
        chk("reset_state_b", 32'(obs_b), 32'(exp_b(0, 0, 0)));

        // Free run: phase patterns, E walk and first strobe after release.
        reset_n = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            chk("freerun", 32'(obs_a), 32'(exp_a(n % 4, (n / 4) % 10, 0)));
            tick();
        end

        // Sync raised mid bus cycle while e_cnt=4.
        repeat (17) tick();
        chk("sync_pre", 32'(obs_a), 32'(exp_a(1, 4, 0)));
        sync_a = 1'b1; tick(); sync_a = 1'b0;
        tick(); tick();
        chk("sync_realign", 32'(obs_a), 32'(exp_a(0, 0, 0)));
        repeat (4) tick();
        chk("sync_no_repeat", 32'(obs_a), 32'(exp_a(0, 1, 0)));

        // Sync on the strobe with e_cnt=9.
        repeat (35) tick();
        chk("sync_wrap_pre", 32'(obs_a), 32'(exp_a(3, 9, 0)));
        sync_a = 1'b1; tick(); sync_a = 1'b0;
        chk("sync_wrap", 32'(obs_a), 32'(exp_a(0, 0, 0)));
        repeat (4) tick();
        chk("sync_wrap_no_pend", 32'(obs_a), 32'(exp_a(0, 1, 0)));
        repeat (35) tick();
        chk("sync_full_period", 32'(obs_a), 32'(exp_a(3, 9, 0)));
        tick();
        chk("sync_full_wrap", 32'(obs_a), 32'(exp_a(0, 0, 0)));

        // Two sync pulses in one bus cycle.
        sync_a = 1'b1; tick(); sync_a = 1'b0; tick();
        sync_a = 1'b1; tick(); sync_a = 1'b0; tick();
        chk("sync_multi", 32'(obs_a), 32'(exp_a(0, 0, 0)));
        repeat (4) tick();
        chk("sync_single", 32'(obs_a), 32'(exp_a(0, 1, 0)));

        // Turbo raised at sub=1, dropped at sub=1 two bus cycles later.
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("turbo_cpu_ce", 32'(cpu_ce_a), 32'(exp_ce[i]));
            chk("turbo_act", 32'(turbo_act_a), 32'(exp_ta[i]));
            if (i == 0) turbo_a = 1'b1;
            if (i == 8) turbo_a = 1'b0;
            tick();
        end
        chk("post_turbo", 32'(obs_a), 32'(exp_a(0, 5, 0)));

        // Asynchronous reset at sub=2, e_cnt=7 with a sync pending.
        repeat (8) tick();
        sync_a = 1'b1; tick(); sync_a = 1'b0; tick();
        chk("pre_reset", 32'(obs_a), 32'(exp_a(2, 7, 0)));
        turbo_a = 1'b1;
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 32'(obs_a), 32'(exp_a(0, 0, 0)));
        turbo_a = 1'b0;
        tick();
        reset_n = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            chk("post_reset", 32'(obs_a), 32'(exp_a(k % 4, k / 4, 0)));
            tick();
        end

        // SUB=8, E_DIV=6 build with turbo requested from release.
        turbo_b = 1'b1;
        rstb_n  = 1'b1;
        n = 0;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            chk("alt_build", 32'(obs_b), 32'(exp_b(n % 8, (n / 8) % 6, n >= 8)));
            if (n >= 16 && n < 24) pulses += int'(cpu_ce_b);
            tick();
        end
        chk("alt_turbo_pulses", 32'(pulses), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
